or_dut_host_master: RTL and testbench
=====================================

Name: or_dut_host_master

Overview:
- Bus initiator for the register-mapped OR-combiner block (A/B operand FIFOs, Y result FIFO).
- Accepts operand pairs on a valid/ready stream and writes A then B, polling the FIFO status registers first.
- Polls Y status, pops the result and returns it on a valid/ready result stream.
- Sits between a test/host sequencer and the combiner's write/read register port.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles spent polling Y status before aborting with error; must be greater than 256, because the combiner fires once per 256-cycle counter period
CNT_W, 16, width of completed-transaction counter

Ports:
CLK  in  1  clock
RST_N  in  1  reset
op_valid  in  1  operand pair valid
op_ready  out  1  operand pair accepted
op_a  in  8  operand A
op_b  in  8  operand B
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  8  result byte (0 on error)
res_err  out  1  result is a timeout abort
write_address  out  3  register write address
write_data  out  8  register write data
write_en  out  1  register write strobe
write_rdy  in  1  responder can accept write
read_address  out  3  register read address
read_en  out  1  read strobe (pops on data addresses)
read_data  in  8  combinational read data for read_address
read_rdy  in  1  responder can accept read
busy  out  1  FSM not in IDLE
txn_count  out  CNT_W  completed transactions, success or error, wrapping
mismatch  out  1  sticky compare failure (see Optional Feature)

Behaviour:
- Reset: RST_N synchronous, active-low; clock CLK.
  - State IDLE; all outputs 0; operand, result and timer registers 0.
  - Reset mid-transaction abandons the transaction; no further bus activity until a new op.
- Register map driven:
  - 0 = A full_n, in bit 0.
  - 1 = B full_n, in bit 0.
  - 2 = Y empty_n, in bit 0.
  - 3 = Y data; pops when read_en=1.
  - 4 = A write.
  - 5 = B write.
- Status polls never assert read_en.
  - Address 0 with read_en dequeues A on the responder, so it must not be strobed.
  - Status bits are sampled combinationally in the same cycle read_address is driven.
  - Bits [7:1] of status reads are ignored.
- FSM; bus outputs decode from the state register only, except the strobe gating noted below:
  - IDLE: op_ready=1. On op_valid, latch op_a/op_b and go to POLL_A.
  - POLL_A: read_address=0. If read_data[0]=1, go to WR_A; else stay.
  - WR_A: write_address=4, write_data=A, write_en=write_rdy. Go to POLL_B on the cycle write_en=1.
  - POLL_B: read_address=1. If read_data[0]=1, go to WR_B.
  - WR_B: write_address=5, write_data=B, write_en=write_rdy. Go to POLL_Y when written; clear the timer.
  - POLL_Y: read_address=2; timer increments every cycle.
    - read_data[0]=1: go to RD_Y.
    - Timer reaches TIMEOUT_CYCLES-1: go to RESP with res_err=1, res_data=0.
    - Y-ready and timeout in the same cycle: Y-ready wins.
  - RD_Y: read_address=3, read_en=read_rdy. On the cycle read_en=1, capture read_data into res_data, set res_err=0, go to RESP.
  - RESP: res_valid=1, outputs held stable. On res_ready, increment txn_count and go to IDLE.
- op_ready is high only in IDLE, so at most one transaction is in flight.
- A timed-out result may later land in Y. It is not flushed; the next transaction will read the stale value. The host treats any res_err as requiring a reset.
- Minimum latency from op accept to res_valid: 7 cycles when all status bits are ready. Typical latency is dominated by the responder's counter==50 gate (up to 256 cycles).

Optional Feature:
- Macro: OR_HOST_CHECK_EN.
- Defined:
  - On a successful RD_Y capture, compare read_data against A|B from the latched operands.
  - On inequality, set mismatch; it stays sticky until reset.
  - Error results are not checked.
- Undefined: mismatch tied to 0 and no compare logic is built.

Decomposition:
- Shared package/header or_host_pkg:
  - Register address constants ADDR_A_FULLN=0, ADDR_B_FULLN=1, ADDR_Y_EMPTYN=2, ADDR_Y_DATA=3, ADDR_A_DATA=4, ADDR_B_DATA=5.
  - FSM state encoding, 3 bits: IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RESP.
- One sub-module is natural: or_host_timer, the POLL_Y timeout counter with clear/enable/expired. Everything else stays in the top module.

Test Plan:
- Ready responder, op A=0x0F, B=0xF0: writes addr4=0x0F then addr5=0xF0; single read_en pulse at addr3; res_data=0xFF, res_err=0, txn_count=1.
- A status held 0 for 20 cycles, then 1: master stays on read_address=0 with read_en=0 and write_en=0 throughout; write proceeds on the first cycle read_data[0]=1.
- write_rdy=0 for 5 cycles in WR_B: write_address=5 held and write_en=0; exactly one write_en pulse after write_rdy rises.
- Y status never set, TIMEOUT_CYCLES=300: res_valid with res_err=1, res_data=0 exactly 300 cycles after entering POLL_Y; no read_en pulse.
- res_ready held low for 10 cycles: res_valid and res_data stable; op_ready stays 0; second op accepted the cycle after the handshake.
- OR_HOST_CHECK_EN, responder returns 0x00 for A=0x01, B=0x02: mismatch=1 and remains set across the next good transaction; undefined build keeps mismatch=0.

Source files
------------

// File: rtl/or_host_pkg.sv
// Shared register map and FSM state encoding for the OR-combiner host master.
package or_host_pkg;

  localparam logic [2:0] ADDR_A_FULLN  = 3'd0;
  localparam logic [2:0] ADDR_B_FULLN  = 3'd1;
  localparam logic [2:0] ADDR_Y_EMPTYN = 3'd2;
  localparam logic [2:0] ADDR_Y_DATA   = 3'd3;
  localparam logic [2:0] ADDR_A_DATA   = 3'd4;
  localparam logic [2:0] ADDR_B_DATA   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POLL_A = 3'd1,
    WR_A   = 3'd2,
    POLL_B = 3'd3,
    WR_B   = 3'd4,
    POLL_Y = 3'd5,
    RD_Y   = 3'd6,
    RESP   = 3'd7
  } host_state_e;

endpackage

// File: rtl/or_host_timer.sv
// POLL_Y timeout counter: cleared on request, counts while enabled, flags the final cycle.
module or_host_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/or_dut_host_master.sv
// Bus initiator for the OR-combiner: polls status, writes A/B, pops Y, returns the result.
// Optional result checking is built when OR_HOST_CHECK_EN is defined.
module or_dut_host_master
  import or_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic [2:0]       write_address,
  output logic [7:0]       write_data,
  output logic             write_en,
  input  logic             write_rdy,
  output logic [2:0]       read_address,
  output logic             read_en,
  input  logic [7:0]       read_data,
  input  logic             read_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             mismatch
);

  host_state_e      state_q, state_d;
  logic [7:0]       opa_q, opb_q;
  logic [7:0]       res_data_q;
  logic             res_err_q;
  logic [CNT_W-1:0] txn_q;
  logic             tmr_clr, tmr_en, tmr_expired;
  logic             y_cap, to_abort, op_take, res_take;

  or_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    op_ready      = 1'b0;
    res_valid     = 1'b0;
    read_address  = ADDR_A_FULLN;
    read_en       = 1'b0;
    write_address = '0;
    write_data    = '0;
    write_en      = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    y_cap         = 1'b0;
    to_abort      = 1'b0;
    op_take       = 1'b0;
    res_take      = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready = RST_N;
        if (op_valid) begin
          op_take = 1'b1;
          state_d = POLL_A;
        end
      end
      POLL_A: begin
        read_address = ADDR_A_FULLN;
        if (read_data[0]) state_d = WR_A;
      end
      WR_A: begin
        write_address = ADDR_A_DATA;
        write_data    = opa_q;
        write_en      = write_rdy;
        if (write_rdy) state_d = POLL_B;
      end
      POLL_B: begin
        read_address = ADDR_B_FULLN;
        if (read_data[0]) state_d = WR_B;
      end
      WR_B: begin
        write_address = ADDR_B_DATA;
        write_data    = opb_q;
        write_en      = write_rdy;
        if (write_rdy) begin
          tmr_clr = 1'b1;
          state_d = POLL_Y;
        end
      end
      POLL_Y: begin
        read_address = ADDR_Y_EMPTYN;
        tmr_en       = 1'b1;
        // Y-ready takes priority over a coincident timeout
        if (read_data[0]) begin
          state_d = RD_Y;
        end else if (tmr_expired) begin
          to_abort = 1'b1;
          state_d  = RESP;
        end
      end
      RD_Y: begin
        read_address = ADDR_Y_DATA;
        read_en      = read_rdy;
        if (read_rdy) begin
          y_cap   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          res_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      txn_q      <= '0;
    end else begin
      state_q <= state_d;
      if (op_take) begin
        opa_q <= op_a;
        opb_q <= op_b;
      end
      if (y_cap) begin
        res_data_q <= read_data;
        res_err_q  <= 1'b0;
      end else if (to_abort) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
      if (res_take) txn_q <= txn_q + CNT_W'(1);
    end
  end

`ifdef OR_HOST_CHECK_EN
  logic mism_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mism_q <= 1'b0;
    end else if (y_cap && (read_data != (opa_q | opb_q))) begin
      mism_q <= 1'b1;
    end
  end

  assign mismatch = mism_q;
`else
  assign mismatch = 1'b0;
`endif

  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign txn_count = txn_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_or_dut_host_master.sv
// Self-checking bench: behavioural combiner responder with randomized readiness plus directed corner cases.
module tb_or_dut_host_master;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        op_valid = 1'b0, op_ready;
  logic [7:0]  op_a = '0, op_b = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [7:0]  res_data;
  logic        res_err;
  logic [2:0]  write_address, read_address;
  logic [7:0]  write_data, read_data;
  logic        write_en, read_en, busy, mismatch;
  logic        write_rdy = 1'b1, read_rdy = 1'b1;
  logic [15:0] txn_count;

  always #5 CLK = ~CLK;

  or_dut_host_master #(
    .TIMEOUT_CYCLES(300),
    .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .write_address(write_address), .write_data(write_data), .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en), .read_data(read_data), .read_rdy(read_rdy),
    .busy(busy), .txn_count(txn_count), .mismatch(mismatch)
  );

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder model: one-deep A/B/Y registers, combiner fires when both operands present
  bit       a_has, b_has, y_has;
  logic [7:0] a_val, b_val, y_val;
  bit       a_ok, b_ok, y_ok, fire;
  bit       all_ready = 1'b1, a_block, y_block, corrupt;
  logic [7:0] junk;
  int       hold_b_left;
  int       cyc = 0;
  int       a_wr_cyc, b_wr_cyc, n_wa, n_wb, n_rd;
  logic [7:0] exp_a, exp_b;
  int       exp_txn = 0;
  int       acc_cyc, rv_cyc;

  always @(posedge CLK) cyc <= cyc + 1;

  always_comb begin
    read_data = junk;
    case (read_address)
      3'd0: read_data = {junk[7:1], !a_has && a_ok && !a_block};
      3'd1: read_data = {junk[7:1], !b_has && b_ok};
      3'd2: read_data = {junk[7:1], y_has && y_ok};
      3'd3: read_data = y_has ? y_val : junk;
      default: read_data = junk;
    endcase
  end

  initial begin : responder
    bit wa, wb, rd, hold_now;
    logic [7:0] wd;
    forever begin
      @(negedge CLK);
      if (all_ready) begin
        write_rdy = 1'b1; read_rdy = 1'b1;
        a_ok = 1'b1; b_ok = 1'b1; y_ok = 1'b1; fire = 1'b1;
      end else begin
        write_rdy = ($urandom_range(0, 3) != 0);
        read_rdy  = ($urandom_range(0, 3) != 0);
        a_ok      = ($urandom_range(0, 3) != 0);
        b_ok      = ($urandom_range(0, 3) != 0);
        y_ok      = ($urandom_range(0, 3) != 0);
        fire      = ($urandom_range(0, 3) != 0);
      end
      junk = 8'($urandom);
      hold_now = 1'b0;
      if (hold_b_left > 0 && busy && write_address == 3'd5) begin
        write_rdy = 1'b0;
        hold_b_left--;
        hold_now = 1'b1;
      end
      #2;
      wa = 1'b0; wb = 1'b0; rd = 1'b0; wd = write_data;
      if (RST_N) begin
        if (write_en) begin
          check_val("wr_rdy", write_rdy, 1);
          if (write_address == 3'd4) begin
            check_val("wr_a_data", write_data, exp_a);
            wa = 1'b1; a_wr_cyc = cyc; n_wa++;
          end else begin
            check_val("wr_addr", write_address, 5);
            check_val("wr_b_data", write_data, exp_b);
            wb = 1'b1; b_wr_cyc = cyc; n_wb++;
          end
        end
        if (hold_now) check_val("wrb_hold_en", write_en, 0);
        if (read_en) begin
          check_val("rd_addr", read_address, 3);
          check_val("rd_rdy", read_rdy, 1);
          check_val("rd_y_present", y_has, 1);
          rd = 1'b1; n_rd++;
        end
      end
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        a_has = 1'b0; b_has = 1'b0; y_has = 1'b0;
      end else begin
        if (wa) begin a_has = 1'b1; a_val = wd; end
        if (wb) begin b_has = 1'b1; b_val = wd; end
        if (rd) y_has = 1'b0;
        if (fire && a_has && b_has && !y_has && !y_block) begin
          y_has = 1'b1;
          y_val = corrupt ? 8'h00 : (a_val | b_val);
          a_has = 1'b0; b_has = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit exp_err);
    logic [7:0] exp_d, d0;
    bit got;
    exp_d = exp_err ? 8'h00 : (corrupt ? 8'h00 : (a | b));
    @(negedge CLK);
    check_val("op_ready_idle", op_ready, 1);
    exp_a = a; exp_b = b; n_wa = 0; n_wb = 0; n_rd = 0;
    op_a = a; op_b = b; op_valid = 1'b1; acc_cyc = cyc;
    @(posedge CLK);
    #1;
    op_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (res_valid) begin got = 1'b1; break; end
    end
    check_val("res_valid_wait", res_valid, 1);
    if (!got) return;
    rv_cyc = cyc;
    check_val("res_data", res_data, exp_d);
    check_val("res_err", res_err, exp_err);
    d0 = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check_val("hold_valid", res_valid, 1);
      check_val("hold_data", res_data, d0);
      check_val("hold_op_ready", op_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge CLK);
    #1;
    res_ready = 1'b0;
    exp_txn++;
    check_val("txn_count", txn_count, 32'(exp_txn));
    check_val("n_wr_a", n_wa, 1);
    check_val("n_wr_b", n_wb, 1);
    check_val("n_rd_y", n_rd, exp_err ? 0 : 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (cycles) @(negedge CLK);
    check_val("rst_busy", busy, 0);
    check_val("rst_res_valid", res_valid, 0);
    check_val("rst_op_ready", op_ready, 0);
    check_val("rst_res_err", res_err, 0);
    check_val("rst_res_data", res_data, 0);
    check_val("rst_txn", txn_count, 0);
    check_val("rst_bus", {write_en, read_en}, 0);
    exp_txn = 0;
    RST_N = 1'b1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int clr_cyc;
    do_reset(3);
    check_val("rst_mismatch", mismatch, 0);

    // all-ready single transaction and minimum latency
    run_op(8'h0F, 8'hF0, 0, 0);
    check_val("min_latency", rv_cyc - acc_cyc, 7);

    // A status held low for 20 cycles
    a_block = 1'b1;
    clr_cyc = 0;
    fork
      run_op(8'h33, 8'h44, 0, 0);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge CLK);
          if (busy) break;
        end
        for (int i = 0; i < 20; i++) begin
          check_val("polla_addr", read_address, 0);
          check_val("polla_rd_en", read_en, 0);
          check_val("polla_wr_en", write_en, 0);
          @(negedge CLK);
        end
        a_block = 1'b0;
        clr_cyc = cyc;
      end
    join
    check_val("a_write_cycle", a_wr_cyc - clr_cyc, 1);

    // write_rdy held low 5 cycles in WR_B
    hold_b_left = 5;
    run_op(8'h5A, 8'hA5, 0, 0);
    check_val("wrb_hold_used", hold_b_left, 0);

    // result back-pressure
    run_op(8'h81, 8'h18, 10, 0);

    // randomized readiness and operands
    all_ready = 1'b0;
    for (int i = 0; i < 30; i++)
      run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), 0);
    all_ready = 1'b1;

    // Y never becomes ready: timeout abort
    y_block = 1'b1;
    run_op(8'h12, 8'h34, 0, 1);
    check_val("timeout_cycles", rv_cyc - b_wr_cyc, 301);
    do_reset(2);
    y_block = 1'b0;

    // reset mid-transaction abandons it
    y_block = 1'b1;
    @(negedge CLK);
    exp_a = 8'h66; exp_b = 8'h99;
    op_a = 8'h66; op_b = 8'h99; op_valid = 1'b1;
    @(posedge CLK);
    #1;
    op_valid = 1'b0;
    repeat (8) @(negedge CLK);
    check_val("mid_busy", busy, 1);
    do_reset(2);
    y_block = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_val("post_rst_idle", {busy, write_en, read_en}, 0);
    end
    run_op(8'hC3, 8'h3C, 1, 0);

    // corrupted combiner result
    corrupt = 1'b1;
    run_op(8'h01, 8'h02, 0, 0);
    corrupt = 1'b0;
`ifdef OR_HOST_CHECK_EN
    check_val("mismatch_set", mismatch, 1);
    run_op(8'h20, 8'h04, 0, 0);
    check_val("mismatch_sticky", mismatch, 1);
`else
    check_val("mismatch_off", mismatch, 0);
    run_op(8'h20, 8'h04, 0, 0);
    check_val("mismatch_off2", mismatch, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
